// File: rtl/scsi_dma_fifo_p.sv
// Byte-packing DMA FIFO between the SCSI byte port and the host longword port.
// Packs bytes into words (DMADIR=1) or unpacks words into bytes (DMADIR=0).
module scsi_dma_fifo_p #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      CPUCLK,
  input  logic                      RESET_,
  input  logic                      DMADIR,
  input  logic                      SB_WR,
  input  logic [7:0]                SB_DIN,
  input  logic                      SB_RD,
  output logic [7:0]                SB_DOUT,
  input  logic                      LW_WR,
  input  logic [DATA_W-1:0]         LW_DIN,
  input  logic                      LW_RD,
  output logic [DATA_W-1:0]         LW_DOUT,
  input  logic                      FLUSH,
  output logic                      FLUSH_DONE,
  output logic                      BOEQ_LAST,
  output logic                      FIFOFULL,
  output logic                      FIFOEMPTY,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      OVF,
  output logic                      UDF
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned BO_W  = $clog2(LANES);
  localparam logic [BO_W-1:0]  BoLast  = BO_W'(LANES - 1);
  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StFlush} state_e;

  state_e            state_q, state_d;
  logic [BO_W-1:0]   bo_q, bo_d;
  logic [PTR_W-1:0]  ni_q, ni_d, no_q, no_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              dir_q, dir_d;
  logic              push, pop, full, empty, flush_done;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // Lane 0 is the most significant byte.
  function automatic logic [DATA_W-1:0] set_lane(input logic [DATA_W-1:0] w,
                                                 input logic [BO_W-1:0]   l,
                                                 input logic [7:0]        b);
    logic [DATA_W-1:0] r;
    r = w;
    r[DATA_W-1-8*int'(l) -: 8] = b;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pad_word(input logic [DATA_W-1:0] w,
                                                 input logic [BO_W-1:0]   l);
    logic [DATA_W-1:0] r;
    r = w;
    for (int i = 0; i < int'(LANES); i++) begin
      if (i >= int'(l)) r[DATA_W-1-8*i -: 8] = 8'h00;
    end
    return r;
  endfunction

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    bo_d       = bo_q;
    hold_d     = hold_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    dir_d      = dir_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush_done = 1'b0;
    mem_wdata  = LW_DIN;
    unique case (state_q)
      StIdle: state_d = DMADIR ? StFill : StDrain;
      StFill: begin
        if (!DMADIR) begin
          state_d = StDrain;
          bo_d    = '0;
          hold_d  = '0;
        end else begin
          if (SB_WR) begin
            if (bo_q != BoLast) begin
              hold_d = set_lane(hold_q, bo_q, SB_DIN);
              bo_d   = bo_q + 1'b1;
            end else if (full) begin
              ovf_d = 1'b1;
            end else begin
              push      = 1'b1;
              mem_wdata = set_lane(hold_q, bo_q, SB_DIN);
              hold_d    = '0;
              bo_d      = '0;
            end
          end
          if (LW_RD) begin
            if (!empty) pop = 1'b1;
            else        udf_d = 1'b1;
          end
          if (FLUSH) begin
            state_d = StFlush;
            dir_d   = 1'b1;
          end
        end
      end
      StDrain: begin
        if (DMADIR) begin
          state_d = StFill;
          bo_d    = '0;
          hold_d  = '0;
        end else begin
          if (LW_WR) begin
            if (!full) push = 1'b1;
            else       ovf_d = 1'b1;
          end
          if (SB_RD) begin
            if (empty) begin
              udf_d = 1'b1;
            end else if (bo_q == BoLast) begin
              pop  = 1'b1;
              bo_d = '0;
            end else begin
              bo_d = bo_q + 1'b1;
            end
          end
          if (FLUSH) begin
            state_d = StFlush;
            dir_d   = 1'b0;
          end
        end
      end
      StFlush: begin
        if (dir_q) begin
          if (LW_RD) begin
            if (!empty) pop = 1'b1;
            else        udf_d = 1'b1;
          end
          // A partial word stalls here until the host frees an entry.
          if (bo_q == '0) begin
            flush_done = 1'b1;
            state_d    = StIdle;
          end else if (!full) begin
            push       = 1'b1;
            mem_wdata  = pad_word(hold_q, bo_q);
            hold_d     = '0;
            bo_d       = '0;
            flush_done = 1'b1;
            state_d    = StIdle;
          end
        end else begin
          if (bo_q != '0 && !empty) pop = 1'b1;
          bo_d       = '0;
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ni_d    = push ? ni_q + 1'b1 : ni_q;
    no_d    = pop  ? no_q + 1'b1 : no_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CPUCLK) begin
    if (!RESET_) begin
      state_q <= StIdle;
      bo_q    <= '0;
      ni_q    <= '0;
      no_q    <= '0;
      count_q <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bo_q    <= bo_d;
      ni_q    <= ni_d;
      no_q    <= no_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dir_q   <= dir_d;
    end
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET_ && push) mem[ni_q] <= mem_wdata;
  end

  assign rd_word    = mem[no_q];
  assign LW_DOUT    = rd_word;
  assign SB_DOUT    = rd_word[DATA_W-1-8*int'(bo_q) -: 8];
  assign FLUSH_DONE = flush_done;
  assign BOEQ_LAST  = (bo_q == BoLast);
  assign FIFOFULL   = full;
  assign FIFOEMPTY  = empty;
  assign COUNT      = count_q;
  assign OVF        = ovf_q;
  assign UDF        = udf_q;

endmodule

// File: tb/tb_scsi_dma_fifo_p.sv
// Self-checking bench for scsi_dma_fifo_p: a 8x32 instance and a 4x16 instance.
module tb_scsi_dma_fifo_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8 x 32 instance
  logic        a_dir = 1'b1, a_sb_wr = 1'b0, a_sb_rd = 1'b0, a_lw_wr = 1'b0, a_lw_rd = 1'b0;
  logic        a_flush = 1'b0;
  logic [7:0]  a_sb_din = '0, a_sb_dout;
  logic [31:0] a_lw_din = '0, a_lw_dout;
  logic        a_fd, a_boeq, a_full, a_empty, a_ovf, a_udf;
  logic [3:0]  a_count;

  // 4 x 16 instance
  logic        b_dir = 1'b0, b_sb_wr = 1'b0, b_sb_rd = 1'b0, b_lw_rd = 1'b0;
  logic [7:0]  b_sb_din = '0, b_sb_dout;
  logic [15:0] b_lw_dout;
  logic        b_fd, b_boeq, b_full, b_empty, b_ovf, b_udf;
  logic [2:0]  b_count;

  scsi_dma_fifo_p #(.DEPTH(8), .DATA_W(32)) u_a (
    .CPUCLK(clk), .RESET_(rst_n), .DMADIR(a_dir), .SB_WR(a_sb_wr), .SB_DIN(a_sb_din),
    .SB_RD(a_sb_rd), .SB_DOUT(a_sb_dout), .LW_WR(a_lw_wr), .LW_DIN(a_lw_din),
    .LW_RD(a_lw_rd), .LW_DOUT(a_lw_dout), .FLUSH(a_flush), .FLUSH_DONE(a_fd),
    .BOEQ_LAST(a_boeq), .FIFOFULL(a_full), .FIFOEMPTY(a_empty), .COUNT(a_count),
    .OVF(a_ovf), .UDF(a_udf)
  );

  scsi_dma_fifo_p #(.DEPTH(4), .DATA_W(16)) u_b (
    .CPUCLK(clk), .RESET_(rst_n), .DMADIR(b_dir), .SB_WR(b_sb_wr), .SB_DIN(b_sb_din),
    .SB_RD(b_sb_rd), .SB_DOUT(b_sb_dout), .LW_WR(1'b0), .LW_DIN(16'h0000),
    .LW_RD(b_lw_rd), .LW_DOUT(b_lw_dout), .FLUSH(1'b0), .FLUSH_DONE(b_fd),
    .BOEQ_LAST(b_boeq), .FIFOFULL(b_full), .FIFOEMPTY(b_empty), .COUNT(b_count),
    .OVF(b_ovf), .UDF(b_udf)
  );

  typedef struct {
    logic       sb_wr;
    logic [7:0] sb_din;
    logic       flush;
    logic [3:0] e_count;
    logic       e_empty;
    logic       e_fd;
    logic       e_boeq;
  } vec_t;

  vec_t        vt[12];
  logic [31:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sb_pop();
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got empty queue, want an entry");
      return 32'hxxxx_xxxx;
    end
    return sb_q.pop_front();
  endfunction

  task automatic push_word(input logic [31:0] w);
    a_lw_din = w;
    a_lw_wr  = 1'b1;
    for (int j = 3; j >= 0; j--) sb_q.push_back({24'h0, w[8*j +: 8]});
    tick();
    a_lw_wr = 1'b0;
  endtask

  task automatic rd_byte(input string nm);
    chk(nm, {24'h0, a_sb_dout}, sb_pop());
    a_sb_rd = 1'b1;
    tick();
    a_sb_rd = 1'b0;
  endtask

  function automatic logic [31:0] mk_word(input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(k * 16);
    b1 = 8'(k * 16 + 1);
    b2 = 8'(k * 16 + 2);
    b3 = 8'(k * 16 + 3);
    return {b0, b1, b2, b3};
  endfunction

  initial begin
    //          sb_wr  din    flush cnt    empty fd    boeq
    vt[0]  = '{1'b1, 8'hAA, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'hBB, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h01, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 8'h02, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h03, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 8'h04, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst count", 32'(a_count), 0);
    chk("rst empty", 32'(a_empty), 1);
    chk("rst full", 32'(a_full), 0);
    chk("rst boeq", 32'(a_boeq), 0);
    chk("rst flush_done", 32'(a_fd), 0);
    chk("rst ovf", 32'(a_ovf), 0);
    chk("rst udf", 32'(a_udf), 0);

    // Pack 32 bytes into a full FIFO
    tick();
    for (int b = 0; b < 32; b++) begin
      a_sb_wr  = 1'b1;
      a_sb_din = 8'(b);
      if (b % 4 == 3) sb_q.push_back({8'(b - 3), 8'(b - 2), 8'(b - 1), 8'(b)});
      tick();
    end
    a_sb_wr = 1'b0;
    chk("pack count", 32'(a_count), 8);
    chk("pack full", 32'(a_full), 1);
    chk("pack lw_dout", a_lw_dout, 32'h0001_0203);

    // Overflow: the fourth byte would commit into a full FIFO
    for (int b = 0; b < 4; b++) begin
      a_sb_wr  = 1'b1;
      a_sb_din = 8'(8'hE0 + b);
      tick();
    end
    a_sb_wr = 1'b0;
    chk("ovf flag", 32'(a_ovf), 1);
    chk("ovf count", 32'(a_count), 8);
    chk("ovf lw_dout", a_lw_dout, 32'h0001_0203);
    chk("ovf bo held", 32'(a_boeq), 1);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pop%0d lw_dout", i), a_lw_dout, sb_pop());
      a_lw_rd = 1'b1;
      tick();
    end
    a_lw_rd = 1'b0;
    chk("pop empty", 32'(a_empty), 1);
    chk("pop ovf sticky", 32'(a_ovf), 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2 ovf", 32'(a_ovf), 0);
    chk("rst2 empty", 32'(a_empty), 1);
    chk("rst2 count", 32'(a_count), 0);

    // Fill-side flush, table driven
    tick();
    for (int i = 0; i < 12; i++) begin
      a_sb_wr  = vt[i].sb_wr;
      a_sb_din = vt[i].sb_din;
      a_flush  = vt[i].flush;
      tick();
      a_sb_wr = 1'b0;
      a_flush = 1'b0;
      chk($sformatf("vec%0d count", i), 32'(a_count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d empty", i), 32'(a_empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d flush_done", i), 32'(a_fd), 32'(vt[i].e_fd));
      chk($sformatf("vec%0d boeq", i), 32'(a_boeq), 32'(vt[i].e_boeq));
    end
    chk("flush padded word", a_lw_dout, 32'hAABB_0000);
    a_lw_rd = 1'b1;
    tick();
    chk("post-flush word", a_lw_dout, 32'h0102_0304);
    tick();
    a_lw_rd = 1'b0;
    chk("flush drained", 32'(a_empty), 1);

    // Unpack two words
    a_dir = 1'b0;
    tick();
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    chk("drain count", 32'(a_count), 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d boeq", i), 32'(a_boeq), (i % 4 == 3) ? 1 : 0);
      rd_byte($sformatf("drain%0d sb_dout", i));
    end
    chk("drain empty", 32'(a_empty), 1);

    // Drain-side flush of a partly consumed word
    push_word(32'h0102_0304);
    a_sb_rd = 1'b1;
    tick();
    a_sb_rd = 1'b0;
    sb_q.delete();
    chk("dflush partial byte", 32'(a_sb_dout), 32'h02);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("dflush done", 32'(a_fd), 1);
    chk("dflush count pre", 32'(a_count), 1);
    tick();
    chk("dflush done pulse", 32'(a_fd), 0);
    chk("dflush empty", 32'(a_empty), 1);

    // Pointer wrap with simultaneous push and pop, then refused push while full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) push_word(mk_word(k));
    chk("wrap count7", 32'(a_count), 7);
    for (int i = 0; i < 3; i++) rd_byte("wrap pre");
    a_lw_din = mk_word(7);
    a_lw_wr  = 1'b1;
    for (int j = 3; j >= 0; j--) sb_q.push_back({24'h0, a_lw_din[8*j +: 8]});
    rd_byte("wrap concurrent");
    a_lw_wr = 1'b0;
    chk("wrap concurrent count", 32'(a_count), 7);
    push_word(mk_word(8));
    chk("wrap full", 32'(a_full), 1);
    for (int i = 0; i < 3; i++) rd_byte("full pre");
    a_lw_din = 32'hDEAD_BEEF;
    a_lw_wr  = 1'b1;
    rd_byte("full concurrent");
    a_lw_wr = 1'b0;
    chk("full concurrent count", 32'(a_count), 7);
    chk("full concurrent ovf", 32'(a_ovf), 1);
    for (int i = 0; i < 28; i++) rd_byte($sformatf("wrap drain%0d", i));
    chk("wrap empty", 32'(a_empty), 1);
    a_sb_rd = 1'b1;
    tick();
    a_sb_rd = 1'b0;
    chk("a udf", 32'(a_udf), 1);
    chk("a udf count", 32'(a_count), 0);

    // 16-bit, depth 4 instance
    b_sb_rd = 1'b1;
    tick();
    b_sb_rd = 1'b0;
    chk("b udf", 32'(b_udf), 1);
    chk("b udf count", 32'(b_count), 0);
    b_dir = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      b_sb_wr  = 1'b1;
      b_sb_din = 8'(8'hC0 + j);
      if (j % 2 == 1) sb_q.push_back({16'h0, 8'(8'hC0 + j - 1), 8'(8'hC0 + j)});
      tick();
    end
    b_sb_wr = 1'b0;
    chk("b count", 32'(b_count), 4);
    chk("b full", 32'(b_full), 1);
    chk("b first word", 32'(b_lw_dout), 32'h0000_C0C1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b pop%0d", i), 32'(b_lw_dout), sb_pop());
      b_lw_rd = 1'b1;
      tick();
    end
    b_lw_rd = 1'b0;
    chk("b empty", 32'(b_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scsi_dma_fifo_p.md
# scsi_dma_fifo_p

Parametrised byte-packing DMA FIFO between the SCSI controller byte port and the 16/32-bit host longword port. It is the generalised successor to the fixed 8-longword, 4-byte SDMAC FIFO, with these parameterised:
- FIFO depth and longword width.
- Byte-offset (BO), next-in (NI) and next-out (NO) pointers, plus the full/empty/BOEQ3-style flags the SCSI state machine consumes.

New behaviour over the fixed FIFO: explicit flush with zero padding, sticky overflow/underflow flags, and an occupancy count.

## Interface
Parameters:
- DEPTH, 8, number of longword entries; power of 2, 2..64.
- DATA_W, 32, host word width; 16 or 32. LANES = DATA_W/8; PTR_W = log2(DEPTH).

Ports:
- CPUCLK  in  1  sole clock; all state updates on rising edge.
- RESET_  in  1  synchronous, active-low reset.
- DMADIR  in  1  1 = SCSI→memory (pack), 0 = memory→SCSI (unpack).
- SB_WR  in  1  SCSI byte write strobe, one byte per cycle.
- SB_DIN  in  8  SCSI byte in.
- SB_RD  in  1  SCSI byte read strobe.
- SB_DOUT  out  8  lane BO of entry NO; combinational.
- LW_WR  in  1  host word push.
- LW_DIN  in  DATA_W  host word in.
- LW_RD  in  1  host word pop.
- LW_DOUT  out  DATA_W  entry NO; combinational.
- FLUSH  in  1  single-cycle flush request.
- FLUSH_DONE  out  1  one-cycle pulse when the flush completes.
- BOEQ_LAST  out  1  BO == LANES-1.
- FIFOFULL  out  1  COUNT == DEPTH.
- FIFOEMPTY  out  1  COUNT == 0.
- COUNT  out  PTR_W+1  committed entries.
- OVF  out  1  sticky; push attempted while full.
- UDF  out  1  sticky; pop attempted while empty.

## Operation
- FSM states:
  - IDLE → FILL when DMADIR=1, → DRAIN when DMADIR=0.
  - FILL/DRAIN → FLUSH on FLUSH=1.
  - FLUSH → IDLE on completion.
  - FILL↔DRAIN on a DMADIR change. The change clears BO and discards the holding register; NI, NO and COUNT are preserved.
- Byte lanes are big-endian: lane 0 = bits [DATA_W-1:DATA_W-8].
- FILL:
  - SB_WR stores SB_DIN into holding-register lane BO, then BO increments.
  - On SB_WR with BO == LANES-1: the completed word, including this byte, is written to mem[NI]; NI increments, COUNT increments, BO wraps to 0.
  - If FIFOFULL at that commit: the word is dropped, OVF is set, NI, COUNT and BO are unchanged (the byte is not stored).
  - LW_RD with !FIFOEMPTY pops: NO increments, COUNT decrements.
  - LW_WR is ignored in FILL.
- DRAIN:
  - LW_WR with !FIFOFULL writes mem[NI]; NI increments, COUNT increments. LW_WR while full sets OVF and is otherwise ignored.
  - SB_RD with !FIFOEMPTY increments BO. At BO == LANES-1 it pops: NO increments, COUNT decrements, BO goes to 0.
  - SB_RD while empty sets UDF and changes nothing else.
- Simultaneous push and pop in one cycle: both pointers advance and COUNT is unchanged. A push while full is still refused even if a pop occurs in the same cycle.
- FLUSH with DMADIR=1:
  - BO == 0: FLUSH_DONE on the next cycle, no commit.
  - BO != 0: lanes BO..LANES-1 are padded with 0x00 and the word is committed. If full, the block waits in FLUSH until a pop frees an entry. SB_WR is ignored while in FLUSH.
- FLUSH with DMADIR=0: a partly consumed entry (BO != 0) is popped and BO is cleared; then FLUSH_DONE.
- Pointers are mod DEPTH. COUNT never exceeds DEPTH and never underflows.
- OVF and UDF clear only on reset.

## Timing
- Reset values (RESET_ low at a rising edge):
  - BO = NI = NO = COUNT = 0, FSM = IDLE.
  - FIFOEMPTY = 1; FIFOFULL, BOEQ_LAST, FLUSH_DONE, OVF, UDF = 0.
  - SB_DOUT and LW_DOUT are don't-care; memory is not cleared.
- Reset mid-operation takes effect at that edge and discards in-flight bytes.
- Flags and COUNT are registered and reflect state after the edge.
- Latency:
  - A last-lane SB_WR at edge N gives updated LW_DOUT, COUNT and FIFOEMPTY after edge N.
  - A DRAIN flush with BO != 0 completes one cycle after FLUSH, with FLUSH_DONE high for that cycle.
  - FLUSH_DONE is never asserted for more than one consecutive cycle.
- IDLE → FILL/DRAIN takes one cycle; strobes received while in IDLE are ignored.

## Test plan
- DEPTH=8, DATA_W=32, DMADIR=1, bytes 0x00..0x1F on SB_WR → COUNT=8, FIFOFULL=1, LW_DOUT=0x00010203; eight LW_RD pops return 0x00010203 ... 0x1C1D1E1F.
- Full FIFO, then 4 more SB_WR → OVF=1, COUNT=8, mem[NO] unchanged; RESET_ low for one edge → OVF=0, FIFOEMPTY=1.
- DMADIR=1, SB_WR 0xAA, 0xBB, then FLUSH → COUNT=1, LW_DOUT=0xAABB0000, FLUSH_DONE pulses one cycle, BO=0.
- DMADIR=0, LW_WR 0x11223344 and 0x55667788, then 8 SB_RD → SB_DOUT sequence 11 22 33 44 55 66 77 88; BOEQ_LAST high on 0x44 and 0x88; FIFOEMPTY=1.
- Wrap and concurrency: with COUNT=7 and NI=7, apply a simultaneous push and pop → COUNT stays 7, NI=0.
- DATA_W=16, DEPTH=4: SB_RD on empty sets UDF; 8 bytes written give COUNT=4, and the first LW_DOUT equals the first two bytes.
